// File: rtl/lfsr_div_pkg.sv
// Shared definitions for the LFSR divider and its receive-side checker.
//   LFSR_W        width of the maximal-length LFSR driving the divider
//   DEF_EXP_HALF  divider half-period in clk cycles (2^LFSR_W - 1)
//   state_t       checker FSM states
package lfsr_div_pkg;

  localparam int unsigned LFSR_W       = 27;
  localparam int unsigned DEF_EXP_HALF = (32'd1 << LFSR_W) - 32'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

endpackage

// File: rtl/lfsr_div_checker_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level plus an edge flop.
//   clk        sampling clock
//   rst_n      asynchronous active-low reset
//   din        asynchronous input level
//   edge_flag  high for one clk cycle per transition of din (either direction)
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic edge_flag
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_flag = s2 ^ s3;

endmodule

// File: rtl/lfsr_div_checker.sv
// Monitor for an LFSR-derived divided clock with a fixed half-period.
// Measures clk cycles between consecutive div_in edges, checks each against
// EXP_HALF +/- TOL, declares lock after LOCK_N consecutive good half-periods and
// flags short, long and stuck half-periods.
//   clk          fabric clock
//   rst_n        asynchronous active-low reset
//   div_in       divided clock under test (may be asynchronous to clk)
//   enable       1 = measure, 0 = return to IDLE
//   clr_err      single-cycle pulse clearing err_count
//   locked       LOCK_N consecutive in-tolerance half-periods seen
//   err_pulse    one-cycle pulse per bad or timed-out half-period
//   err_count    saturating error count
//   last_period  most recent measured half-period, held between edges
module lfsr_div_checker
  import lfsr_div_pkg::*;
#(
  parameter int unsigned EXP_HALF = DEF_EXP_HALF,
  parameter int unsigned TOL      = 2,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned CNT_W    = 28,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_in,
  input  logic             enable,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] last_period
);

  localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(EXP_HALF + TOL + 1);
  localparam int unsigned      GOOD_W  = $clog2(LOCK_N + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic              edge_flag;
  logic              in_win;

  sync_edge_det u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (div_in),
    .edge_flag (edge_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      last_q    <= last_d;
    end
  end

  assign in_win = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    last_d   = last_q;

    // cnt_q at an edge is the cycle count since the previous edge
    if (edge_flag)
      cnt_d = CNT_W'(1);
    else if (cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;

    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d    = '0;
          good_d   = '0;
          locked_d = 1'b0;
          state_d  = ACQUIRE;
        end
        ACQUIRE: begin
          if (edge_flag)
            state_d = MEASURE;
        end
        MEASURE, LOCKED: begin
          // an edge coinciding with the timeout count is measured, not timed out
          if (edge_flag) begin
            last_d = cnt_q;
            if (in_win) begin
              if (state_q == MEASURE) begin
                good_d = good_q + 1'b1;
                if (good_q == GOOD_LAST) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                end
              end
            end else begin
              err_d    = 1'b1;
              good_d   = '0;
              locked_d = 1'b0;
              state_d  = MEASURE;
            end
          end else if (cnt_q == TIMEOUT) begin
            err_d    = 1'b1;
            good_d   = '0;
            locked_d = 1'b0;
            state_d  = ACQUIRE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // a clear coinciding with a new error leaves that error counted
    if (clr_err)
      err_cnt_d = err_d ? ERR_W'(1) : '0;
    else if (err_d && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 1'b1;
    else
      err_cnt_d = err_cnt_q;
  end

  assign locked      = locked_q;
  assign err_pulse   = err_q;
  assign err_count   = err_cnt_q;
  assign last_period = last_q;

endmodule

// File: tb/tb_lfsr_div_checker.sv
module tb_lfsr_div_checker;

  localparam int EXP_HALF = 10;
  localparam int TOL      = 1;
  localparam int LOCK_N   = 3;
  localparam int CNT_W    = 28;
  localparam int ERR_W    = 4;
  localparam int TO       = EXP_HALF + TOL + 1;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;
  localparam int FOREVER  = 32'h3fff_ffff;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             div_in  = 1'b0;
  logic             enable  = 1'b0;
  logic             clr_err = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] last_period;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // scoreboard: cycle numbers at which err_pulse must be observed
  int exp_q[$];

  // half-period level reference model
  int mst;       // 0 idle, 1 acquire, 2 measure, 3 locked
  int mgood;
  int merr;
  int mlast;
  int last_e;
  int last_tog;
  bit mlocked;

  lfsr_div_checker #(
    .EXP_HALF (EXP_HALF),
    .TOL      (TOL),
    .LOCK_N   (LOCK_N),
    .CNT_W    (CNT_W),
    .ERR_W    (ERR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_in      (div_in),
    .enable      (enable),
    .clr_err     (clr_err),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .last_period (last_period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL err_pulse_missing: actual none, required pulse at cycle %0d", exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (err_pulse === 1'b1) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        void'(exp_q.pop_front());
      end else begin
        errors++;
        $display("FAIL err_pulse_unexpected: actual 1 at cycle %0d, required 0", cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void m_err(input int at);
    exp_q.push_back(at);
    if (merr != ERR_MAX) merr++;
  endfunction

  // an edge later than last_e+TO means the DUT times out first
  function automatic void predict_timeout(input int next_e);
    if (mst >= 2 && next_e > last_e + TO) begin
      m_err(last_e + TO);
      mst = 1; mgood = 0; mlocked = 0;
    end
  endfunction

  function automatic void model_edge(input int e);
    int p;
    p = e - last_e;
    last_e = e;
    if (mst == 1) begin
      mst = 2;
    end else if (mst >= 2) begin
      mlast = p;
      if (p >= EXP_HALF - TOL && p <= EXP_HALF + TOL) begin
        if (mst == 2) begin
          mgood++;
          if (mgood == LOCK_N) begin mst = 3; mlocked = 1; end
        end
      end else begin
        m_err(e);
        mgood = 0; mlocked = 0; mst = 2;
      end
    end
  endfunction

  function automatic void model_reset();
    mst = 0; mgood = 0; merr = 0; mlast = 0; last_e = 0; mlocked = 0;
  endfunction

  // edge flag is sampled 3 clk after the pin toggles
  task automatic toggle_after(input int h);
    predict_timeout(last_tog + h + 3);
    while (cyc < last_tog + h) @(negedge clk);
    div_in   = ~div_in;
    last_tog = cyc;
    model_edge(cyc + 3);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; div_in = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: actual %b, required 0", locked); end
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: actual %b, required 0", err_pulse); end
    checks++;
    if (err_count !== '0) begin errors++; $display("FAIL reset_err_count: actual %0d, required 0", err_count); end
    checks++;
    if (last_period !== '0) begin errors++; $display("FAIL reset_last_period: actual %0d, required 0", last_period); end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    enable = 1'b1; mst = 1; last_tog = cyc;
  endtask

  task automatic test_lock_acquire();
    for (int i = 0; i < 4; i++) toggle_after(EXP_HALF);
    wait_until(last_tog + 2);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: actual %b, required 0 two cycles after 4th toggle", locked); end
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL lock_acquire: actual %b, required %b", locked, mlocked); end
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL lock_err_count: actual %0d, required %0d", err_count, merr); end
    checks++;
    if (last_period !== CNT_W'(mlast)) begin errors++; $display("FAIL lock_last_period: actual %0d, required %0d", last_period, mlast); end
  endtask

  task automatic test_bad_period();
    // edge lands exactly on the timeout count: measured as a long period
    toggle_after(TO);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL long_locked: actual %b, required %b", locked, mlocked); end
    checks++;
    if (last_period !== CNT_W'(mlast)) begin errors++; $display("FAIL long_last_period: actual %0d, required %0d", last_period, mlast); end
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL long_err_count: actual %0d, required %0d", err_count, merr); end
    for (int i = 0; i < LOCK_N; i++) toggle_after(EXP_HALF);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL relock_after_long: actual %b, required %b", locked, mlocked); end
  endtask

  task automatic test_window();
    toggle_after(EXP_HALF - TOL);
    toggle_after(EXP_HALF + TOL);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL window_edges_locked: actual %b, required %b", locked, mlocked); end
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL window_edges_err_count: actual %0d, required %0d", err_count, merr); end
    toggle_after(EXP_HALF - TOL - 1);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL short_locked: actual %b, required %b", locked, mlocked); end
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL short_err_count: actual %0d, required %0d", err_count, merr); end
    checks++;
    if (last_period !== CNT_W'(mlast)) begin errors++; $display("FAIL short_last_period: actual %0d, required %0d", last_period, mlast); end
    for (int i = 0; i < LOCK_N; i++) toggle_after(EXP_HALF);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL relock_after_short: actual %b, required %b", locked, mlocked); end
  endtask

  task automatic test_timeout();
    predict_timeout(FOREVER);
    wait_until(last_tog + 3 * TO);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL timeout_locked: actual %b, required %b", locked, mlocked); end
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL timeout_err_count: actual %0d, required %0d", err_count, merr); end
    last_tog = cyc;
    toggle_after(4);
    for (int i = 0; i < LOCK_N; i++) toggle_after(EXP_HALF);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL relock_after_timeout: actual %b, required %b", locked, mlocked); end
  endtask

  task automatic test_saturation();
    int c;
    for (int i = 0; i < 20; i++) toggle_after(6);
    wait_until(last_tog + 3);
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL err_count_saturate: actual %0d, required %0d", err_count, merr); end
    toggle_after(6);
    c = last_tog;
    wait_until(c + 2);
    clr_err = 1'b1;
    wait_until(c + 3);
    clr_err = 1'b0;
    merr = 1;
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL clr_with_error: actual %0d, required %0d", err_count, merr); end
    wait_until(c + 4);
    clr_err = 1'b1;
    wait_until(c + 5);
    clr_err = 1'b0;
    merr = 0;
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL clr_alone: actual %0d, required %0d", err_count, merr); end
    for (int i = 0; i < LOCK_N; i++) toggle_after(EXP_HALF);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL relock_after_saturation: actual %b, required %b", locked, mlocked); end
  endtask

  task automatic test_back_to_back_err();
    // two bad edges then a good one: only the bad edges pulse
    toggle_after(7);
    toggle_after(5);
    toggle_after(EXP_HALF);
    wait_until(last_tog + 3);
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL back_to_back_err_count: actual %0d, required %0d", err_count, merr); end
    for (int i = 0; i < LOCK_N - 1; i++) toggle_after(EXP_HALF);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL back_to_back_relock: actual %b, required %b", locked, mlocked); end
  endtask

  task automatic test_disable();
    int held_err;
    held_err = merr;
    enable = 1'b0;
    mst = 0; mgood = 0; mlocked = 0;
    @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL disable_locked: actual %b, required 0", locked); end
    checks++;
    if (err_count !== ERR_W'(held_err)) begin errors++; $display("FAIL disable_err_hold: actual %0d, required %0d", err_count, held_err); end
    checks++;
    if (last_period !== CNT_W'(mlast)) begin errors++; $display("FAIL disable_last_hold: actual %0d, required %0d", last_period, mlast); end
    repeat (2 * TO) @(negedge clk);
    enable = 1'b1; mst = 1;
    @(negedge clk);
    last_tog = cyc;
    toggle_after(4);
    for (int i = 0; i < LOCK_N; i++) toggle_after(EXP_HALF);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL relock_after_enable: actual %b, required %b", locked, mlocked); end
    checks++;
    if (err_count !== ERR_W'(held_err)) begin errors++; $display("FAIL enable_err_hold: actual %0d, required %0d", err_count, held_err); end
  endtask

  task automatic test_reset_mid();
    wait_until(last_tog + 5);
    #2;
    rst_n  = 1'b0;
    div_in = 1'b0;
    model_reset();
    #1;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL midreset_locked: actual %b, required 0", locked); end
    checks++;
    if (err_count !== '0) begin errors++; $display("FAIL midreset_err_count: actual %0d, required 0", err_count); end
    checks++;
    if (last_period !== '0) begin errors++; $display("FAIL midreset_last_period: actual %0d, required 0", last_period); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mst = 1;
    @(negedge clk);
    last_tog = cyc;
    toggle_after(3);
    for (int i = 0; i < LOCK_N; i++) toggle_after(EXP_HALF);
    wait_until(last_tog + 3);
    checks++;
    if (locked !== mlocked) begin errors++; $display("FAIL relock_after_reset: actual %b, required %b", locked, mlocked); end
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL postreset_err_count: actual %0d, required %0d", err_count, merr); end
  endtask

  task automatic test_drain();
    predict_timeout(FOREVER);
    wait_until(last_tog + 3 * TO);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size()); end
    checks++;
    if (err_count !== ERR_W'(merr)) begin errors++; $display("FAIL final_err_count: actual %0d, required %0d", err_count, merr); end
  endtask

  initial begin
    model_reset();
    last_tog = 0;
    @(negedge clk);
    test_reset();
    test_lock_acquire();
    test_bad_period();
    test_window();
    test_timeout();
    test_saturation();
    test_back_to_back_err();
    test_disable();
    test_reset_mid();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
